main_mem_responder: RTL

Main-memory responder for the cache subsystem: the memory-side end of the cache-to-main-memory request interface. It accepts single-cycle block-read requests (returns a 64-byte block) and word-write requests (commits one 32-bit word) with fixed, parameterised latencies, and signals completion with a one-cycle `mem_ready` pulse. It sits below the cache controller in both the integrated design and the cache testbench, backed by an internal block-organised storage array.

---
 rtl/main_mem_responder.sv | 115 +++++++++++
 1 files changed

// File: rtl/main_mem_responder.sv
// main_mem_responder
//   Memory-side end of the cache-to-main-memory request interface. Accepts
//   one block read (returns a 64-byte block) or one word write at a time and
//   completes it after a fixed, parameterised latency with a one-cycle
//   mem_ready pulse. Storage is block-organised and is not cleared by reset.
// Ports
//   clk, rst_n        clock, async active-low reset
//   mem_addr[31:0]    byte address: [31:6] block, [5:2] word, [1:0] ignored
//   mem_wdata[31:0]   write word, sampled with mem_write_req
//   mem_read_req      block-read request (sampled only when idle)
//   mem_write_req     word-write request (sampled only when idle)
//   mem_rdata[511:0]  last read block, word k at [32k+31:32k]
//   mem_ready         one-cycle completion pulse
//   mem_err           coincident with mem_ready when the request was in error
//   busy              request outstanding
//   req_overrun       sticky: a request arrived while busy
module main_mem_responder #(
  parameter int DEPTH_BLOCKS  = 256,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  mem_addr,
  input  logic [31:0]  mem_wdata,
  input  logic         mem_read_req,
  input  logic         mem_write_req,
  output logic [511:0] mem_rdata,
  output logic         mem_ready,
  output logic         mem_err,
  output logic         busy,
  output logic         req_overrun
);
  localparam int AW   = $clog2(DEPTH_BLOCKS);
  localparam int MAXL = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW   = $clog2(MAXL) + 1;   // holds MAXL-1, never zero width

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [25:0]     blk;
  logic [3:0]      word;
  logic [31:0]     wdata;
  logic            both_err;   // read+write presented together
  logic            oor;
  logic            done;

  logic [15:0][31:0] mem [DEPTH_BLOCKS];

  // Byte-lane bits are architecturally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];

  // Power-of-two depth: any set bit above the index field is out of range.
  assign oor  = (blk >> AW) != '0;
  assign done = (state != IDLE) && (cnt == '0);
  assign busy = (state != IDLE);

  // Storage has no reset; a reset mid-write forces IDLE so the commit never fires.
  always_ff @(posedge clk) begin
    if (done && state == WR_WAIT && !oor)
      mem[blk[AW-1:0]][word] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      blk         <= '0;
      word        <= '0;
      wdata       <= '0;
      both_err    <= 1'b0;
      mem_rdata   <= '0;
      mem_ready   <= 1'b0;
      mem_err     <= 1'b0;
      req_overrun <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read_req) begin
            state    <= RD_WAIT;
            cnt      <= CW'(READ_LATENCY - 1);
            blk      <= mem_addr[31:6];
            word     <= mem_addr[5:2];
            both_err <= mem_write_req;   // write side is dropped
          end else if (mem_write_req) begin
            state    <= WR_WAIT;
            cnt      <= CW'(WRITE_LATENCY - 1);
            blk      <= mem_addr[31:6];
            word     <= mem_addr[5:2];
            wdata    <= mem_wdata;
            both_err <= 1'b0;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (mem_read_req || mem_write_req)
            req_overrun <= 1'b1;
          if (cnt == '0) begin
            state     <= IDLE;
            mem_ready <= 1'b1;
            mem_err   <= both_err | oor;
            if (state == RD_WAIT)
              mem_rdata <= oor ? '0 : mem[blk[AW-1:0]];
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
